// File: rtl/hud_pkg.sv
// Shared HUD constants and the tag carried alongside each glyph ROM read.
package hud_pkg;
  localparam int GLYPH_PIXELS = 100;
  localparam int GLYPH_DIGITS = 10;
  localparam int ROM_ADDR_BIT = 9;

  localparam logic REQ_SCORE = 1'b0;
  localparam logic REQ_TIME  = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
    logic blank;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);
endpackage

// File: rtl/glyph_rom_arbiter_if.sv
// Printer request/return signals and glyph ROM port shared by the arbiter and its neighbours.
interface glyph_rom_arbiter_if #(
  parameter int ROM_ADDR_BIT = 9
);
  logic                  req_score;
  logic [3:0]            digit_score;
  logic [7:0]            index_score;
  logic                  req_time;
  logic [3:0]            digit_time;
  logic [7:0]            index_time;
  logic                  busy_score;
  logic                  busy_time;
  logic                  rom_rd;
  logic [ROM_ADDR_BIT:0] rom_addr;
  logic                  rom_data;
  logic                  pix_score;
  logic                  pix_score_valid;
  logic                  pix_time;
  logic                  pix_time_valid;
  logic [1:0]            err_flags;

  modport slave (
    input  req_score, digit_score, index_score,
    input  req_time, digit_time, index_time,
    input  rom_data,
    output busy_score, busy_time, rom_rd, rom_addr,
    output pix_score, pix_score_valid, pix_time, pix_time_valid, err_flags
  );

  modport master (
    output req_score, digit_score, index_score,
    output req_time, digit_time, index_time,
    output rom_data,
    input  busy_score, busy_time, rom_rd, rom_addr,
    input  pix_score, pix_score_valid, pix_time, pix_time_valid, err_flags
  );
endinterface

// File: rtl/glyph_tag_pipe.sv
// Tag shift register that follows each granted read through the ROM latency.
module glyph_tag_pipe
  import hud_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk_i,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/glyph_rom_arbiter.sv
// Arbitrates score/timer pixel reads onto the shared digit glyph ROM and routes pixels back.
// Define ARB_FIXED_PRIO_EN for fixed score-first priority instead of round-robin.
module glyph_rom_arbiter #(
  parameter int ROM_ADDR_BIT = 9,
  parameter int GLYPH_PIXELS = 100,
  parameter int ROM_LATENCY  = 2
) (
  input logic                clock_25,
  input logic                reset,
  input logic                sync_reset,
  glyph_rom_arbiter_if.slave bus
);
  import hud_pkg::*;

  localparam int AW = ROM_ADDR_BIT + 1;

  function automatic logic [AW-1:0] glyph_addr(input logic [3:0] digit, input logic [7:0] index);
    return AW'(digit) * AW'(GLYPH_PIXELS) + AW'(index);
  endfunction

  logic          clr;
  logic          slot_s_full_q, slot_s_full_d, slot_t_full_q, slot_t_full_d;
  logic [3:0]    slot_s_digit_q, slot_s_digit_d, slot_t_digit_q, slot_t_digit_d;
  logic [7:0]    slot_s_index_q, slot_s_index_d, slot_t_index_q, slot_t_index_d;
  logic          cand_s, cand_t, contest, win_time, gnt_vld, gnt_blank, drop;
  logic [3:0]    gnt_digit;
  logic [7:0]    gnt_index;
  logic          rom_rd_q, rom_rd_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]    err_q, err_d;
  logic          pix_s_q, pix_s_d, pix_s_vld_q, pix_s_vld_d;
  logic          pix_t_q, pix_t_d, pix_t_vld_q, pix_t_vld_d;
  tag_t          tag_in, tag_out;
`ifdef ARB_FIXED_PRIO_EN
`else
  logic          rr_q, rr_d;
`endif

  assign clr = !reset || sync_reset;

  // A full pending slot always outranks its requester's live request.
  always_comb begin
    cand_s  = slot_s_full_q | bus.req_score;
    cand_t  = slot_t_full_q | bus.req_time;
    contest = cand_s & cand_t;
`ifdef ARB_FIXED_PRIO_EN
    win_time = cand_t & ~cand_s;
`else
    win_time = cand_t & (~cand_s | rr_q);
`endif
    gnt_vld = cand_s | cand_t;
    if (win_time) begin
      gnt_digit = slot_t_full_q ? slot_t_digit_q : bus.digit_time;
      gnt_index = slot_t_full_q ? slot_t_index_q : bus.index_time;
    end else begin
      gnt_digit = slot_s_full_q ? slot_s_digit_q : bus.digit_score;
      gnt_index = slot_s_full_q ? slot_s_index_q : bus.index_score;
    end
    gnt_blank = (gnt_digit > 4'(GLYPH_DIGITS - 1)) || (gnt_index > 8'(GLYPH_PIXELS - 1));
    drop      = (bus.req_score & slot_s_full_q) | (bus.req_time & slot_t_full_q);
  end

  always_comb begin
    slot_s_full_d  = slot_s_full_q;
    slot_s_digit_d = slot_s_digit_q;
    slot_s_index_d = slot_s_index_q;
    slot_t_full_d  = slot_t_full_q;
    slot_t_digit_d = slot_t_digit_q;
    slot_t_index_d = slot_t_index_q;
    if (contest && !win_time && !slot_t_full_q) begin
      slot_t_full_d  = 1'b1;
      slot_t_digit_d = bus.digit_time;
      slot_t_index_d = bus.index_time;
    end
    if (contest && win_time && !slot_s_full_q) begin
      slot_s_full_d  = 1'b1;
      slot_s_digit_d = bus.digit_score;
      slot_s_index_d = bus.index_score;
    end
    if (gnt_vld && !win_time && slot_s_full_q) slot_s_full_d = 1'b0;
    if (win_time && slot_t_full_q)             slot_t_full_d = 1'b0;

    err_d      = err_q | {drop, gnt_vld & gnt_blank};
    rom_rd_d   = gnt_vld & ~gnt_blank;
    rom_addr_d = rom_rd_d ? glyph_addr(gnt_digit, gnt_index) : rom_addr_q;
    tag_in     = '{valid: gnt_vld, id: (win_time ? REQ_TIME : REQ_SCORE), blank: gnt_blank};

    // Tail tag lines up with rom_data; blank reads return 0 regardless of the ROM.
    pix_s_vld_d = tag_out.valid & (tag_out.id == REQ_SCORE);
    pix_t_vld_d = tag_out.valid & (tag_out.id == REQ_TIME);
    pix_s_d     = pix_s_vld_d ? (bus.rom_data & ~tag_out.blank) : pix_s_q;
    pix_t_d     = pix_t_vld_d ? (bus.rom_data & ~tag_out.blank) : pix_t_q;
`ifdef ARB_FIXED_PRIO_EN
`else
    rr_d = rr_q ^ contest;
`endif
  end

  always_ff @(posedge clock_25) begin
    if (clr) begin
      slot_s_full_q <= 1'b0;
      slot_t_full_q <= 1'b0;
      rom_rd_q      <= 1'b0;
      rom_addr_q    <= '0;
      err_q         <= '0;
      pix_s_q       <= 1'b0;
      pix_s_vld_q   <= 1'b0;
      pix_t_q       <= 1'b0;
      pix_t_vld_q   <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
      rr_q          <= 1'b0;
`endif
    end else begin
      slot_s_full_q <= slot_s_full_d;
      slot_t_full_q <= slot_t_full_d;
      rom_rd_q      <= rom_rd_d;
      rom_addr_q    <= rom_addr_d;
      err_q         <= err_d;
      pix_s_q       <= pix_s_d;
      pix_s_vld_q   <= pix_s_vld_d;
      pix_t_q       <= pix_t_d;
      pix_t_vld_q   <= pix_t_vld_d;
`ifdef ARB_FIXED_PRIO_EN
`else
      rr_q          <= rr_d;
`endif
    end
  end

  always_ff @(posedge clock_25) begin
    slot_s_digit_q <= slot_s_digit_d;
    slot_s_index_q <= slot_s_index_d;
    slot_t_digit_q <= slot_t_digit_d;
    slot_t_index_q <= slot_t_index_d;
  end

  glyph_tag_pipe #(.DEPTH(ROM_LATENCY + 1)) u_tag_pipe (
    .clk_i (clock_25),
    .clr_i (clr),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.busy_score      = slot_s_full_q;
  assign bus.busy_time       = slot_t_full_q;
  assign bus.rom_rd          = rom_rd_q;
  assign bus.rom_addr        = rom_addr_q;
  assign bus.pix_score       = pix_s_q;
  assign bus.pix_score_valid = pix_s_vld_q;
  assign bus.pix_time        = pix_t_q;
  assign bus.pix_time_valid  = pix_t_vld_q;
  assign bus.err_flags       = err_q;
endmodule

// File: doc/glyph_rom_arbiter.md
Name: glyph_rom_arbiter

Overview:
- Shares the single number-glyph ROM (ten 10x10 digit bitmaps, 1 bit/pixel) between the score printer and the timer printer.
- Each printer issues per-pixel read requests (digit, pixel index 0..99); the block arbitrates, forms the ROM address, tracks each read through the ROM pipeline and returns the pixel to the originating printer.
- Sits between the score/time controllers and the glyph ROM, feeding the VGA pixel mux.

Parameters:
- ROM_ADDR_BIT, 9, ROM address MSB index (address is [9:0]; 1000 entries used).
- GLYPH_PIXELS, 100, pixels per glyph; address = digit*GLYPH_PIXELS + index.
- ROM_LATENCY, 2, clocks from rom_rd/rom_addr to valid rom_data (1..4 supported).

Ports:
- clock_25  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-low reset.
- sync_reset  in  1  synchronous game-restart clear, active-high.
- req_score  in  1  score printer read request, one pixel per asserted cycle.
- digit_score  in  4  digit 0..9 for score request.
- index_score  in  8  pixel index 0..99 for score request.
- req_time  in  1  timer printer read request.
- digit_time  in  4  digit for timer request.
- index_time  in  8  pixel index for timer request.
- busy_score  out  1  score pending slot full; new score requests are not accepted.
- busy_time  out  1  timer pending slot full.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ROM_ADDR_BIT+1  ROM address.
- rom_data  in  1  ROM pixel, valid ROM_LATENCY clocks after rom_rd.
- pix_score  out  1  returned score pixel.
- pix_score_valid  out  1  pix_score valid strobe.
- pix_time  out  1  returned timer pixel.
- pix_time_valid  out  1  pix_time valid strobe.
- err_flags  out  2  sticky: [0] out-of-range request, [1] request dropped while busy.

Behaviour:
- Reset: reset low at a clock edge, or sync_reset high, clears all outputs to 0, empties both pending slots, invalidates the tag pipeline, sets the RR pointer to "score next" and clears err_flags.
  - In-flight reads are discarded; no valid strobe follows.
  - reset has priority over sync_reset.
- Candidates per requester each cycle: its pending slot if full, otherwise its live request.
  - A live request arriving while the slot is full is ignored and sets err_flags[1].
- Arbitration: one grant per cycle.
  - Single candidate: that candidate wins.
  - Two candidates: round-robin; the winner is the one not granted last, and the pointer flips on every contested grant.
  - The loser's request is copied into its pending slot, unless it was already pending. busy_<x> is high the cycle after capture and stays high until the slot is granted.
- Issue: the granted request at cycle N drives registered rom_rd=1 and rom_addr = digit*100 + index at N+1.
  - Multiply by constant, 10-bit result, no truncation for legal inputs.
- Range: digit>9 or index>99 consumes the grant slot but does not drive rom_rd; rom_addr holds its previous value. The returned pixel is forced to 0 and err_flags[0] is set.
- Tag pipeline: ROM_LATENCY+1 stages carry {valid, requester id, blank}.
  - Output is registered at N+2+ROM_LATENCY (default 4 clocks after the request).
  - Exactly one of pix_score_valid / pix_time_valid pulses per granted request.
  - pix_<x> holds its last value when its valid is low.
- Ordering: per requester, pixels return in request order. Total throughput is 1 pixel/clock.
- Simultaneous capture and grant of the same requester's pending slot in one cycle is impossible by construction, since the slot has priority.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, score always wins contested cycles and the RR pointer is removed.
- Undefined: round-robin as above.
- Latency, pending slots and error flags are identical in both modes.

Decomposition:
- Shared package hud_pkg holds:
  - constants GLYPH_PIXELS=100, GLYPH_DIGITS=10, ROM_ADDR_BIT;
  - requester id encoding REQ_SCORE=1'b0, REQ_TIME=1'b1;
  - tag struct/width {valid, id, blank}.
- One sub-module, glyph_tag_pipe: parameterised shift register of ROM_LATENCY+1 tag stages, with a clear input driven by reset/sync_reset.

Test Plan:
- Single score request, digit 7, index 23: rom_rd=1 and rom_addr=723 one clock later; pix_score_valid pulses 4 clocks after the request, with pix_score equal to the ROM bit; pix_time_valid stays 0.
- Both requesters in the same cycle (score 3/5, time 8/99), first contest: score issued (addr 305), busy_time=1 for one clock, time issued next cycle (addr 899); valids 4 and 5 clocks after the request. A second contest grants time first.
- Continuous back-to-back score requests, indices 0..99 of digit 9: rom_addr runs 900..999 one per clock with no bubbles; 100 valid pulses returned in order.
- Timer request with digit 12 index 5: no rom_rd; pix_time_valid pulses at the normal latency with pix_time=0; err_flags[0]=1 and stays set until reset.
- Contest, then a new time request while busy_time=1: the new request is ignored and err_flags[1]=1. Separately, assert sync_reset with 3 reads in flight: no further valid pulses, busy/err cleared.
- Build with ARB_FIXED_PRIO_EN: repeat the simultaneous-request case twice; score wins both contests.
